// File: rtl/seq_detect_driver_if.sv
// Host/detector-side signal bundle for seq_detect_driver.
// The slave modport is the driver's view; the master modport is the host/bench view,
// which supplies the run request and the two detector outputs.
interface seq_detect_driver_if #(
  parameter int WIDTH = 16
);
  localparam int CW = $clog2(WIDTH + 2);

  logic             start;
  logic [WIDTH-1:0] pattern;
  logic [CW-1:0]    length;
  logic             busy;
  logic             done;
  logic             x_out;
  logic             det_reset;
  logic             q_mealy;
  logic             q_moore;
  logic [CW-1:0]    det_count;
  logic [CW-1:0]    mismatch_count;
  logic             mismatch;

  modport slave (
    input  start, pattern, length, q_mealy, q_moore,
    output busy, done, x_out, det_reset, det_count, mismatch_count, mismatch
  );

  modport master (
    output start, pattern, length, q_mealy, q_moore,
    input  busy, done, x_out, det_reset, det_count, mismatch_count, mismatch
  );
endinterface

// File: rtl/seq_detect_driver.sv
// Sequencing controller for a Mealy/Moore sequence-detector pair.
// Resets the detectors for one cycle, shifts the loaded pattern LSB first onto X,
// counts Mealy hits and flags cycles where Moore disagrees with Mealy delayed by one.
module seq_detect_driver #(
  parameter int WIDTH = 16
) (
  input  logic                clk,
  input  logic                reset,
  seq_detect_driver_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 2);

  typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    rem_q, rem_d;
  logic [CW-1:0]    det_cnt_q, det_cnt_d;
  logic [CW-1:0]    mis_cnt_q, mis_cnt_d;
  logic             mis_q, mis_d;
  logic             mealy_dly_q, mealy_dly_d;
  logic             det_reset_q, det_reset_d;
  logic [CW-1:0]    len_clamped;

  // A length of zero or beyond the register width means "send the whole register".
  always_comb begin
    len_clamped = bus.length;
    if (bus.length == '0 || bus.length > CW'(WIDTH))
      len_clamped = CW'(WIDTH);
  end

  // Next-state and datapath update; the Moore compare runs in RUN and once more in DRAIN.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    rem_d       = rem_q;
    det_cnt_d   = det_cnt_q;
    mis_cnt_d   = mis_cnt_q;
    mis_d       = mis_q;
    mealy_dly_d = mealy_dly_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          shreg_d     = bus.pattern;
          rem_d       = len_clamped;
          det_cnt_d   = '0;
          mis_cnt_d   = '0;
          mis_d       = 1'b0;
          mealy_dly_d = 1'b0;
          state_d     = CLEAR;
        end
      end
      CLEAR: state_d = RUN;
      RUN: begin
        if (bus.q_mealy)
          det_cnt_d = det_cnt_q + CW'(1);
        if (bus.q_moore != mealy_dly_q) begin
          mis_cnt_d = mis_cnt_q + CW'(1);
          mis_d     = 1'b1;
        end
        mealy_dly_d = bus.q_mealy;
        shreg_d     = {1'b0, shreg_q[WIDTH-1:1]};
        rem_d       = rem_q - CW'(1);
        if (rem_q == CW'(1))
          state_d = DRAIN;
      end
      DRAIN: begin
        if (bus.q_moore != mealy_dly_q) begin
          mis_cnt_d = mis_cnt_q + CW'(1);
          mis_d     = 1'b1;
        end
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Detectors are held in reset (active-low) only during the CLEAR cycle.
    det_reset_d = (state_d != CLEAR);
  end

  // State and datapath registers; async reset also holds the detectors in reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      rem_q       <= '0;
      det_cnt_q   <= '0;
      mis_cnt_q   <= '0;
      mis_q       <= 1'b0;
      mealy_dly_q <= 1'b0;
      det_reset_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      rem_q       <= rem_d;
      det_cnt_q   <= det_cnt_d;
      mis_cnt_q   <= mis_cnt_d;
      mis_q       <= mis_d;
      mealy_dly_q <= mealy_dly_d;
      det_reset_q <= det_reset_d;
    end
  end

  // Outputs decode state and registers only, so no input reaches an output combinationally.
  assign bus.busy           = (state_q == CLEAR) || (state_q == RUN) || (state_q == DRAIN);
  assign bus.done           = (state_q == DONE);
  assign bus.x_out          = (state_q == RUN) && shreg_q[0];
  assign bus.det_reset      = det_reset_q;
  assign bus.det_count      = det_cnt_q;
  assign bus.mismatch_count = mis_cnt_q;
  assign bus.mismatch       = mis_q;
endmodule
